// File: rtl/typing_session_ctrl.sv
// rtl/typing_session_ctrl.sv - typing trainer session FSM: line fetch, keystroke scoring, timed play, BCD result
module typing_session_ctrl #(
  parameter int LINE_LEN   = 8,
  parameter int TIME_LIMIT = 60,
  parameter int CNT_W      = 10,
  parameter int SCORE_MUL  = 3,
  parameter int PENALTY    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          key_valid,
  input  logic [7:0]                    key_ascii,
  input  logic                          tick,
  output logic                          word_req,
  input  logic                          word_ack,
  input  logic [8*LINE_LEN-1:0]         word_data,
  output logic [8*LINE_LEN-1:0]         line_out,
  output logic [8*LINE_LEN-1:0]         next_line_out,
  output logic                          line_load,
  output logic                          char_wr,
  output logic [$clog2(LINE_LEN)-1:0]   char_idx,
  output logic [2:0]                    state,
  output logic [CNT_W-1:0]              correct_cnt,
  output logic [CNT_W-1:0]              miss_cnt,
  output logic [9:0]                    time_left,
  output logic [15:0]                   result_bcd,
  output logic                          result_valid
);

  localparam int IW = $clog2(LINE_LEN);
  localparam int LW = 8 * LINE_LEN;
  localparam logic [IW-1:0] LAST_IDX   = IW'(LINE_LEN - 1);
  localparam logic [9:0]    TIME_INIT  = 10'(TIME_LIMIT);
  localparam logic [7:0]    KEY_ENTER  = 8'h0D;
  localparam logic [7:0]    KEY_ESC    = 8'h1B;
  localparam logic [47:0]   TXT_TITLE  = "typing";
  localparam logic [47:0]   TXT_RESULT = "Result";

  typedef enum logic [2:0] {
    TITLE_INIT = 3'd0,
    TITLE      = 3'd1,
    FETCH      = 3'd2,
    PLAY       = 3'd3,
    STALL      = 3'd4,
    CALC       = 3'd5,
    RESULT     = 3'd6
  } state_t;

  // Left-align a 6-character banner into a line, zero padding the tail.
  function automatic logic [LW-1:0] pack_text(input logic [47:0] txt);
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < 6 && i < LINE_LEN; i++) begin
      r[LW-1-8*i -: 8] = txt[47-8*i -: 8];
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // One double-dabble step: add 3 to any BCD digit >= 5, then shift left.
  function automatic logic [29:0] dabble(input logic [29:0] v);
    logic [29:0] t;
    t = v;
    for (int d = 0; d < 4; d++) begin
      if (t[14+4*d +: 4] >= 4'd5) begin
        t[14+4*d +: 4] = t[14+4*d +: 4] + 4'd3;
      end
    end
    return t << 1;
  endfunction

  state_t             state_q;
  logic [LW-1:0]      line_q;
  logic [LW-1:0]      next_q;
  logic [LW-1:0]      refill_q;
  logic               held_q;
  logic               word_req_q;
  logic               fetch_cnt_q;
  logic               line_load_q;
  logic               char_wr_q;
  logic [IW-1:0]      char_idx_q;
  logic [CNT_W-1:0]   correct_q;
  logic [CNT_W-1:0]   miss_q;
  logic [9:0]         time_q;
  logic [15:0]        bcd_q;
  logic [3:0]         calc_cnt_q;
  logic [29:0]        dd_q;

  logic [7:0]         cur_char;
  logic [7:0]         nxt_char;
  logic               line_done;
  logic               ack_ok;
  logic               have_refill;
  logic [LW-1:0]      refill_data;
  logic [31:0]        gain;
  logic [31:0]        loss;
  logic [13:0]        score;
  logic [29:0]        dd_step;

  // Expected character at the cursor and the one after it (0 past the end).
  always_comb begin
    cur_char = '0;
    nxt_char = '0;
    for (int i = 0; i < LINE_LEN; i++) begin
      if (IW'(i) == char_idx_q) cur_char = line_q[LW-1-8*i -: 8];
      if (i > 0 && IW'(i - 1) == char_idx_q) nxt_char = line_q[LW-1-8*i -: 8];
    end
  end

  assign line_done   = (char_idx_q == LAST_IDX) || (nxt_char == 8'h00);
  assign ack_ok      = word_req_q && word_ack;
  // An ack landing in the completing cycle counts as a held refill.
  assign have_refill = held_q || ack_ok;
  assign refill_data = held_q ? refill_q : word_data;

  // Penalised score, floored at zero and clamped to four decimal digits.
  always_comb begin
    gain  = 32'(SCORE_MUL) * 32'(correct_q);
    loss  = 32'(PENALTY) * 32'(miss_q);
    score = '0;
    if (loss >= gain) begin
      score = '0;
    end else if ((gain - loss) > 32'd9999) begin
      score = 14'd9999;
    end else begin
      score = 14'(gain - loss);
    end
  end

  assign dd_step = dabble(dd_q);

  // Session FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= TITLE_INIT;
      line_q      <= '0;
      next_q      <= '0;
      refill_q    <= '0;
      held_q      <= 1'b0;
      word_req_q  <= 1'b0;
      fetch_cnt_q <= 1'b0;
      line_load_q <= 1'b0;
      char_wr_q   <= 1'b0;
      char_idx_q  <= '0;
      correct_q   <= '0;
      miss_q      <= '0;
      time_q      <= TIME_INIT;
      bcd_q       <= '0;
      calc_cnt_q  <= '0;
      dd_q        <= '0;
    end else begin
      line_load_q <= 1'b0;
      char_wr_q   <= 1'b0;
      case (state_q)
        TITLE_INIT: begin
          line_q      <= pack_text(TXT_TITLE);
          next_q      <= '0;
          line_load_q <= 1'b1;
          word_req_q  <= 1'b0;
          held_q      <= 1'b0;
          state_q     <= TITLE;
        end

        TITLE, RESULT: begin
          if (key_valid && key_ascii == KEY_ENTER) begin
            correct_q   <= '0;
            miss_q      <= '0;
            time_q      <= TIME_INIT;
            bcd_q       <= '0;
            char_idx_q  <= '0;
            fetch_cnt_q <= 1'b0;
            held_q      <= 1'b0;
            word_req_q  <= 1'b1;
            state_q     <= FETCH;
          end
        end

        FETCH: begin
          if (ack_ok) begin
            if (!fetch_cnt_q) begin
              next_q      <= word_data;
              fetch_cnt_q <= 1'b1;
              word_req_q  <= 1'b0;
            end else begin
              line_q      <= next_q;
              next_q      <= word_data;
              line_load_q <= 1'b1;
              char_idx_q  <= '0;
              word_req_q  <= 1'b1;
              state_q     <= PLAY;
            end
          end else if (!word_req_q) begin
            word_req_q <= 1'b1;
          end
        end

        PLAY, STALL: begin
          if (tick) time_q <= time_q - 10'd1;
          if (tick && time_q == 10'd1) begin
            word_req_q <= 1'b0;
            held_q     <= 1'b0;
            calc_cnt_q <= '0;
            state_q    <= CALC;
          end else if (key_valid && key_ascii == KEY_ESC) begin
            word_req_q <= 1'b0;
            held_q     <= 1'b0;
            state_q    <= TITLE_INIT;
          end else if (state_q == STALL) begin
            if (ack_ok) begin
              line_q      <= next_q;
              next_q      <= word_data;
              line_load_q <= 1'b1;
              char_idx_q  <= '0;
              word_req_q  <= 1'b1;
              state_q     <= PLAY;
            end
          end else begin
            if (ack_ok) begin
              refill_q   <= word_data;
              held_q     <= 1'b1;
              word_req_q <= 1'b0;
            end
            if (key_valid) begin
              if (key_ascii == cur_char) begin
                correct_q <= sat_inc(correct_q);
                if (line_done) begin
                  if (have_refill) begin
                    line_q      <= next_q;
                    next_q      <= refill_data;
                    char_idx_q  <= '0;
                    line_load_q <= 1'b1;
                    word_req_q  <= 1'b1;
                    held_q      <= 1'b0;
                  end else begin
                    state_q <= STALL;
                  end
                end else begin
                  char_idx_q <= char_idx_q + IW'(1);
                  char_wr_q  <= 1'b1;
                end
              end else begin
                miss_q <= sat_inc(miss_q);
              end
            end
          end
        end

        CALC: begin
          word_req_q <= 1'b0;
          if (calc_cnt_q == 4'd0) begin
            dd_q       <= {16'b0, score};
            calc_cnt_q <= 4'd1;
          end else begin
            dd_q       <= dd_step;
            calc_cnt_q <= calc_cnt_q + 4'd1;
            if (calc_cnt_q == 4'd14) begin
              bcd_q       <= dd_step[29:14];
              line_q      <= pack_text(TXT_RESULT);
              next_q      <= '0;
              line_load_q <= 1'b1;
              state_q     <= RESULT;
            end
          end
        end

        default: state_q <= TITLE_INIT;
      endcase
    end
  end

  assign word_req      = word_req_q;
  assign line_out      = line_q;
  assign next_line_out = next_q;
  assign line_load     = line_load_q;
  assign char_wr       = char_wr_q;
  assign char_idx      = char_idx_q;
  assign state         = state_q;
  assign correct_cnt   = correct_q;
  assign miss_cnt      = miss_q;
  assign time_left     = time_q;
  assign result_bcd    = bcd_q;
  assign result_valid  = (state_q == RESULT);

endmodule
